// File: rtl/dotmatrix_pkg.sv
// Shared definitions for the dot-matrix cursor front end and cursor stage.
// Direction indices are fixed so that both stages agree on the bit order of move vectors.
package dotmatrix_pkg;

    localparam int unsigned DIR_UP    = 0;
    localparam int unsigned DIR_DOWN  = 1;
    localparam int unsigned DIR_RIGHT = 2;
    localparam int unsigned DIR_LEFT  = 3;
    localparam int unsigned NUM_DIRS  = 4;

    typedef logic [NUM_DIRS-1:0] dir_vec_t;

    // Lowest index wins: up > down > right > left.
    function automatic dir_vec_t pick_highest(input dir_vec_t req);
        dir_vec_t grant;
        logic     found;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_DIRS; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/dotmatrix_key_debounce.sv
// One raw button: 2-flop synchroniser, stable-level debounce and a registered press flag
// that is high for the single cycle after the stable level rises.
module dotmatrix_key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync   <= '0;
            count  <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else if (clear) begin
            sync   <= '0;
            count  <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            // The sample that completes the stable run is accepted on the same edge.
            if (sync[1] == stable) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                count  <= '0;
                stable <= sync[1];
                rise   <= sync[1];
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dotmatrix_key_conditioner.sv
// Turns four raw direction buttons into debounced, auto-repeating, one-hot move pulses,
// serialised so the cursor stage sees at most one move per clock.
module dotmatrix_key_conditioner
    import dotmatrix_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_PERIOD   = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic power,
    input  logic up,
    input  logic down,
    input  logic right,
    input  logic left,
    output logic up_p,
    output logic down_p,
    output logic right_p,
    output logic left_p,
    output logic move_valid
);

    localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] HOLD_FIRE   = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

    dir_vec_t raw;
    dir_vec_t stable;
    dir_vec_t rise;
    dir_vec_t repeat_hit;
    dir_vec_t pending;
    dir_vec_t pending_next;
    dir_vec_t grant;

    logic [NUM_DIRS-1:0][HW-1:0] hold;
    logic [NUM_DIRS-1:0][HW-1:0] hold_next;

    assign raw[DIR_UP]    = up;
    assign raw[DIR_DOWN]  = down;
    assign raw[DIR_RIGHT] = right;
    assign raw[DIR_LEFT]  = left;

    for (genvar g = 0; g < NUM_DIRS; g++) begin : g_key
        dotmatrix_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .clear  (~power),
            .raw    (raw[g]),
            .stable (stable[g]),
            .rise   (rise[g])
        );
    end

    // Hold counters: the edge that would reach REPEAT_DELAY fires and reloads instead.
    always_comb begin
        hold_next  = hold;
        repeat_hit = '0;
        for (int unsigned i = 0; i < NUM_DIRS; i++) begin
            if (rise[i]) begin
                hold_next[i] = '0;
            end else if (stable[i]) begin
                if (hold[i] == HOLD_FIRE) begin
                    repeat_hit[i] = 1'b1;
                    hold_next[i]  = HOLD_RELOAD;
                end else if (hold[i] != HOLD_MAX) begin
                    hold_next[i] = hold[i] + 1'b1;
                end
            end else begin
                hold_next[i] = '0;
            end
        end
    end

    // A new event on a key being issued this cycle is absorbed by the issue.
    always_comb begin
        grant        = pick_highest(pending);
        pending_next = (pending | rise | repeat_hit) & ~grant;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            hold       <= '0;
            up_p       <= 1'b0;
            down_p     <= 1'b0;
            right_p    <= 1'b0;
            left_p     <= 1'b0;
            move_valid <= 1'b0;
        end else if (!power) begin
            pending    <= '0;
            hold       <= '0;
            up_p       <= 1'b0;
            down_p     <= 1'b0;
            right_p    <= 1'b0;
            left_p     <= 1'b0;
            move_valid <= 1'b0;
        end else begin
            pending    <= pending_next;
            hold       <= hold_next;
            up_p       <= grant[DIR_UP];
            down_p     <= grant[DIR_DOWN];
            right_p    <= grant[DIR_RIGHT];
            left_p     <= grant[DIR_LEFT];
            move_valid <= |grant;
        end
    end

endmodule

// File: tb/tb_dotmatrix_key_conditioner.sv
// Scoreboard bench: each press schedules its expected pulses by cycle; every falling edge
// compares the four pulses and move_valid against the scoreboard head (zero when none due).
module tb_dotmatrix_key_conditioner;
    import dotmatrix_pkg::*;

    localparam int unsigned LAT = 8; // drive negedge -> pulse seen at negedge (D+3 after sampling edge)

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic power = 1'b1;
    logic up = 1'b0, down = 1'b0, right = 1'b0, left = 1'b0;
    logic up_p, down_p, right_p, left_p, move_valid;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  dir;
    } exp_t;

    exp_t sb[$];

    dotmatrix_key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .power      (power),
        .up         (up),
        .down       (down),
        .right      (right),
        .left       (left),
        .up_p       (up_p),
        .down_p     (down_p),
        .right_p    (right_p),
        .left_p     (left_p),
        .move_valid (move_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, want);
        end
    endtask

    task automatic expect_pulse(input int c, input int unsigned d);
        exp_t e;
        int   idx;
        e.cyc  = c;
        e.dir  = '0;
        e.dir[d] = 1'b1;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [3:0] exp_v;
        logic [3:0] obs;
        exp_v = '0;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missed_pulse_cycle", 32'(cyc), 32'(sb[0].cyc));
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_v = sb[0].dir;
            void'(sb.pop_front());
        end
        obs = {left_p, right_p, down_p, up_p};
        check("pulses", 32'(obs), 32'(exp_v));
        check("move_valid", 32'(move_valid), 32'(|exp_v));
    end

    initial begin
        int k;
        int offs[7];
        offs = '{0, 10, 15, 20, 25, 30, 35};

        // Power-on reset
        #1 reset = 1'b0;
        #1;
        check("rst_up_p", 32'(up_p), 0);
        check("rst_move_valid", 32'(move_valid), 0);
        wait_cycles(3);
        #2 reset = 1'b1;
        wait_cycles(3);

        // 1: clean press, released before first repeat
        @(negedge clk);
        k = cyc;
        down = 1'b1;
        expect_pulse(k + LAT, DIR_DOWN);
        wait_cycles(10);
        down = 1'b0;
        wait_cycles(20);

        // 2: bounce shorter than the debounce window, then a real press
        for (int i = 0; i < 6; i++) begin
            right = (i % 2 == 0);
            wait_cycles(2);
        end
        right = 1'b0;
        wait_cycles(12);
        k = cyc;
        right = 1'b1;
        expect_pulse(k + LAT, DIR_RIGHT);
        wait_cycles(8);
        right = 1'b0;
        wait_cycles(20);

        // 3: simultaneous down and right serialise in priority order
        k = cyc;
        down  = 1'b1;
        right = 1'b1;
        expect_pulse(k + LAT, DIR_DOWN);
        expect_pulse(k + LAT + 1, DIR_RIGHT);
        wait_cycles(8);
        down  = 1'b0;
        right = 1'b0;
        wait_cycles(20);

        // 4: auto-repeat while held
        k = cyc;
        up = 1'b1;
        foreach (offs[i]) expect_pulse(k + LAT + offs[i], DIR_UP);
        wait_cycles(38);
        up = 1'b0;
        wait_cycles(30);

        // 5: reset while up repeats and left is pending
        k = cyc;
        up = 1'b1;
        expect_pulse(k + LAT, DIR_UP);
        expect_pulse(k + LAT + 10, DIR_UP);
        wait_cycles(11);
        left = 1'b1;
        wait_cycles(7);
        #2 reset = 1'b0;
        #1;
        check("async_rst_up_p", 32'(up_p), 0);
        check("async_rst_left_p", 32'(left_p), 0);
        check("async_rst_move_valid", 32'(move_valid), 0);
        wait_cycles(3);
        #2 reset = 1'b1;
        expect_pulse(k + 29, DIR_UP);
        expect_pulse(k + 30, DIR_LEFT);
        wait_cycles(9);
        up   = 1'b0;
        left = 1'b0;
        wait_cycles(20);

        // 6: power gating holds everything clear, new press after power returns
        power = 1'b0;
        wait_cycles(2);
        up = 1'b1;
        wait_cycles(20);
        check("pwr_off_move_valid", 32'(move_valid), 0);
        k = cyc;
        power = 1'b1;
        expect_pulse(k + LAT, DIR_UP);
        wait_cycles(10);
        up = 1'b0;
        wait_cycles(20);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
